// File: rtl/mem_log_mc.sv
// Multi-bank capture logger: writes accepted samples round-robin across N_BANK
// single-port RAM banks and reads back one full row at a time.
module mem_log_mc #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int N_BANK = 2,
    parameter int DEC_W  = 8
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_data_valid,
    input  logic                     i_run_log,
    input  logic                     i_stop,
    input  logic                     i_mode,
    input  logic [DEC_W-1:0]         i_decim,
    input  logic                     i_read_log,
    input  logic [ADDR_W-1:0]        i_addr_log,
    output logic                     o_busy,
    output logic                     o_mem_full,
    output logic                     o_wrapped,
    output logic [ADDR_W-1:0]        o_wr_ptr,
    output logic [N_BANK*DATA_W-1:0] o_data_log,
    output logic                     o_data_valid
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam int                BANK_W   = (N_BANK > 1) ? $clog2(N_BANK) : 1;
    localparam logic [ADDR_W-1:0] ROW_MAX  = {ADDR_W{1'b1}};
    localparam logic [BANK_W-1:0] BANK_MAX = BANK_W'(N_BANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2,
        ST_READ = 2'd3
    } state_t;

    state_t            state_r;
    logic              mode_r;
    logic [DEC_W-1:0]  decim_r;
    logic [DEC_W-1:0]  dec_cnt_r;
    logic [BANK_W-1:0] bank_cnt_r;
    logic [ADDR_W-1:0] row_cnt_r;
    logic              wrapped_r;
    logic              busy_r;
    logic              full_r;
    logic              dvalid_r;

    logic              start_s;
    logic              acc_s;
    logic              bank_wrap_s;
    logic              last_s;
    logic              stop_s;
    logic              re_s;

    // Per-cycle decode of capture start, sample acceptance, fill end and read service.
    always_comb begin
        start_s     = 1'b0;
        acc_s       = 1'b0;
        bank_wrap_s = 1'b0;
        last_s      = 1'b0;
        stop_s      = 1'b0;
        re_s        = 1'b0;

        if (i_run_log && (state_r != ST_RUN)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end

        if ((state_r == ST_RUN) && i_data_valid && (dec_cnt_r == {DEC_W{1'b0}})) begin
            acc_s = 1'b1;
        end else begin
            acc_s = 1'b0;
        end

        bank_wrap_s = (bank_cnt_r == BANK_MAX);

        // Single-shot ends on the sample that fills the last bank of the last row.
        if (acc_s && !mode_r && bank_wrap_s && (row_cnt_r == ROW_MAX)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end

        if ((state_r == ST_RUN) && mode_r && i_stop) begin
            stop_s = 1'b1;
        end else begin
            stop_s = 1'b0;
        end

        // A run request in FULL/READ wins over a simultaneous read.
        if (((state_r == ST_FULL) || (state_r == ST_READ)) && i_read_log && !i_run_log) begin
            re_s = 1'b1;
        end else begin
            re_s = 1'b0;
        end
    end

    // Capture FSM with counters and registered status outputs.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            mode_r     <= 1'b0;
            decim_r    <= {DEC_W{1'b0}};
            dec_cnt_r  <= {DEC_W{1'b0}};
            bank_cnt_r <= {BANK_W{1'b0}};
            row_cnt_r  <= {ADDR_W{1'b0}};
            wrapped_r  <= 1'b0;
            busy_r     <= 1'b0;
            full_r     <= 1'b0;
            dvalid_r   <= 1'b0;
        end else begin
            dvalid_r <= re_s;
            if (start_s) begin
                state_r    <= ST_RUN;
                mode_r     <= i_mode;
                decim_r    <= i_decim;
                dec_cnt_r  <= {DEC_W{1'b0}};
                bank_cnt_r <= {BANK_W{1'b0}};
                row_cnt_r  <= {ADDR_W{1'b0}};
                wrapped_r  <= 1'b0;
                busy_r     <= 1'b1;
                full_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        busy_r <= 1'b0;
                        full_r <= 1'b0;
                    end
                    ST_RUN: begin
                        if (i_data_valid) begin
                            dec_cnt_r <= (dec_cnt_r == decim_r) ? {DEC_W{1'b0}}
                                                                : dec_cnt_r + DEC_W'(1);
                        end
                        if (acc_s) begin
                            bank_cnt_r <= bank_wrap_s ? {BANK_W{1'b0}} : bank_cnt_r + BANK_W'(1);
                            if (bank_wrap_s) begin
                                row_cnt_r <= row_cnt_r + ADDR_W'(1);
                                if ((row_cnt_r == ROW_MAX) && mode_r) begin
                                    wrapped_r <= 1'b1;
                                end
                            end
                        end
                        if (stop_s || last_s) begin
                            state_r <= ST_FULL;
                            busy_r  <= 1'b0;
                            full_r  <= 1'b1;
                        end
                    end
                    ST_FULL, ST_READ: begin
                        if (i_read_log) begin
                            state_r <= ST_READ;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        full_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < N_BANK; k++) begin : g_bank
            logic [DATA_W-1:0] mem_r [DEPTH];
            logic [DATA_W-1:0] rd_q_r;

            // Bank RAM: write while capturing, read while full; never both in one state.
            always_ff @(posedge clk) begin
                if (acc_s && (bank_cnt_r == BANK_W'(k))) begin
                    mem_r[row_cnt_r] <= i_data;
                end
                if (re_s) begin
                    rd_q_r <= mem_r[i_addr_log];
                end
            end

            assign o_data_log[(N_BANK-k)*DATA_W-1 -: DATA_W] = rd_q_r;
        end
    endgenerate

    assign o_busy       = busy_r;
    assign o_mem_full   = full_r;
    assign o_wrapped    = wrapped_r;
    assign o_wr_ptr     = row_cnt_r;
    assign o_data_valid = dvalid_r;

endmodule

// File: tb/tb_mem_log_mc.sv
// Self-checking bench for mem_log_mc: directed scenarios plus randomized
// circular captures, checked against a sample-index reference model.
module tb_mem_log_mc;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int NB    = 2;
    localparam int DCW   = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic [DW-1:0]    i_data = '0;
    logic             i_data_valid = 1'b0;
    logic             i_run_log = 1'b0;
    logic             i_stop = 1'b0;
    logic             i_mode = 1'b0;
    logic [DCW-1:0]   i_decim = '0;
    logic             i_read_log = 1'b0;
    logic [AW-1:0]    i_addr_log = '0;
    logic             o_busy;
    logic             o_mem_full;
    logic             o_wrapped;
    logic [AW-1:0]    o_wr_ptr;
    logic [NB*DW-1:0] o_data_log;
    logic             o_data_valid;

    mem_log_mc #(.ADDR_W(AW), .DATA_W(DW), .N_BANK(NB), .DEC_W(DCW)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_run_log    (i_run_log),
        .i_stop       (i_stop),
        .i_mode       (i_mode),
        .i_decim      (i_decim),
        .i_read_log   (i_read_log),
        .i_addr_log   (i_addr_log),
        .o_busy       (o_busy),
        .o_mem_full   (o_mem_full),
        .o_wrapped    (o_wrapped),
        .o_wr_ptr     (o_wr_ptr),
        .o_data_log   (o_data_log),
        .o_data_valid (o_data_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: capture described by valid-sample and accepted-sample indices.
    bit            m_run = 1'b0;
    bit            m_full = 1'b0;
    bit            m_mode = 1'b0;
    int            m_decim = 0;
    int            m_vcnt = 0;
    int            m_acc = 0;
    bit            m_wrapped = 1'b0;
    logic [DW-1:0] ref_mem [NB][DEPTH];
    bit            ref_known [NB][DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic run, input logic stop,
                       input logic rd, input logic [AW-1:0] a, input logic md,
                       input logic [DCW-1:0] dc);
        bit            exp_rdv;
        bit            exp_known;
        logic [63:0]   exp_row;
        exp_rdv   = 1'b0;
        exp_known = 1'b0;
        exp_row   = '0;
        i_data_valid = v;
        i_data       = d;
        i_run_log    = run;
        i_stop       = stop;
        i_read_log   = rd;
        i_addr_log   = a;
        i_mode       = md;
        i_decim      = dc;
        @(posedge clk);
        exp_rdv = m_full && rd && !run;
        if (exp_rdv) begin
            exp_known = ref_known[0][a] && ref_known[1][a];
            exp_row   = 64'({ref_mem[0][a], ref_mem[1][a]});
        end
        if (run && !m_run) begin
            m_run = 1'b1; m_full = 1'b0; m_mode = md; m_decim = int'(dc);
            m_vcnt = 0; m_acc = 0; m_wrapped = 1'b0;
        end else if (m_run) begin
            if (v) begin
                if (m_vcnt % (m_decim + 1) == 0) begin
                    ref_mem[m_acc % NB][(m_acc / NB) % DEPTH]   = d;
                    ref_known[m_acc % NB][(m_acc / NB) % DEPTH] = 1'b1;
                    m_acc++;
                    if (m_mode && (m_acc % (NB * DEPTH) == 0)) m_wrapped = 1'b1;
                end
                m_vcnt++;
            end
            if ((m_mode && stop) || (!m_mode && m_acc == NB * DEPTH)) begin
                m_run = 1'b0; m_full = 1'b1;
            end
        end
        #1;
        chk("busy", 64'(o_busy), 64'(m_run));
        chk("mem_full", 64'(o_mem_full), 64'(m_full));
        chk("wrapped", 64'(o_wrapped), 64'(m_wrapped));
        chk("wr_ptr", 64'(o_wr_ptr), 64'((m_acc / NB) % DEPTH));
        chk("data_valid", 64'(o_data_valid), 64'(exp_rdv));
        if (exp_rdv && exp_known) chk("data_log", 64'(o_data_log), exp_row);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic sample(input logic [DW-1:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, a, 1'b0, '0);
    endtask

    task automatic start(input logic md, input logic [DCW-1:0] dc);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, md, dc);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without a clock.
    task automatic mid_reset();
        #2 i_rst = 1'b1;
        #1;
        m_run = 1'b0; m_full = 1'b0; m_wrapped = 1'b0; m_acc = 0; m_vcnt = 0;
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_full", 64'(o_mem_full), 64'(0));
        chk("rst_wr_ptr", 64'(o_wr_ptr), 64'(0));
        chk("rst_dvalid", 64'(o_data_valid), 64'(0));
        #1 i_rst = 1'b0;
    endtask

    initial begin
        int guard;
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < DEPTH; r++) ref_known[b][r] = 1'b0;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        chk("por_busy", 64'(o_busy), 64'(0));
        chk("por_full", 64'(o_mem_full), 64'(0));
        chk("por_wrapped", 64'(o_wrapped), 64'(0));
        chk("por_wr_ptr", 64'(o_wr_ptr), 64'(0));
        chk("por_dvalid", 64'(o_data_valid), 64'(0));
        i_rst = 1'b0;
        idle(2);
        rd(4'd3);

        // Single-shot fill with 40 samples; 33..40 must be ignored.
        start(1'b0, 8'd0);
        for (int i = 1; i <= 40; i++) begin
            sample(DW'(i));
            if (i == 31) chk("ss_not_full_31", 64'(o_mem_full), 64'(0));
            if (i == 32) chk("ss_full_32", 64'(o_mem_full), 64'(1));
        end
        chk("ss_wrapped", 64'(o_wrapped), 64'(0));
        rd(4'd0);
        chk("ss_row0", 64'(o_data_log), 64'({16'd1, 16'd2}));
        rd(4'd15);
        chk("ss_row15", 64'(o_data_log), 64'({16'd31, 16'd32}));
        for (int i = 0; i < 6; i++) rd(AW'($urandom_range(0, DEPTH - 1)));
        idle(1);

        // Decimation 2 with alternating valid; re-run from READ.
        start(1'b0, 8'd2);
        chk("rerun_full_drop", 64'(o_mem_full), 64'(0));
        chk("rerun_row0", 64'(o_wr_ptr), 64'(0));
        for (int i = 1; i <= 96; i++) cyc(1'(i % 2), DW'(i), 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        guard = 0;
        while (!m_full && guard < 3000) begin
            cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'b0, 1'($urandom_range(0, 1)),
                1'b0, '0, 1'b0, '0);
            guard++;
        end
        chk("decim_fill", 64'(o_mem_full), 64'(1));
        rd(4'd0);
        chk("decim_row0", 64'(o_data_log), 64'({16'd1, 16'd7}));
        rd(4'd1);
        chk("decim_row1", 64'(o_data_log), 64'({16'd13, 16'd19}));

        // Circular capture of 40 samples then stop.
        start(1'b1, 8'd0);
        for (int i = 1; i <= 40; i++) sample(DW'(i));
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("circ_wr_ptr", 64'(o_wr_ptr), 64'(4));
        chk("circ_wrapped", 64'(o_wrapped), 64'(1));
        rd(4'd0);
        chk("circ_row0", 64'(o_data_log), 64'({16'd33, 16'd34}));
        rd(4'd3);
        chk("circ_row3", 64'(o_data_log), 64'({16'd39, 16'd40}));
        rd(4'd4);
        chk("circ_row4", 64'(o_data_log), 64'({16'd9, 16'd10}));
        rd(4'd15);
        chk("circ_row15", 64'(o_data_log), 64'({16'd31, 16'd32}));

        // Stop mid-row together with a run request.
        start(1'b1, 8'd0);
        for (int i = 1; i <= 5; i++) sample(DW'(i));
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("stopmid_full", 64'(o_mem_full), 64'(1));
        chk("stopmid_wr_ptr", 64'(o_wr_ptr), 64'(2));
        rd(4'd2);
        chk("stopmid_row2", 64'(o_data_log), 64'({16'd5, 16'd38}));

        // Randomized circular captures with noisy controls.
        for (int ep = 0; ep < 4; ep++) begin
            start(1'b1, DCW'($urandom_range(0, 3)));
            for (int i = 0; i < int'($urandom_range(20, 150)); i++)
                cyc(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 7) == 0),
                    1'b0, 1'($urandom_range(0, 3) == 0), AW'($urandom), 1'($urandom), DCW'($urandom));
            cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
            for (int i = 0; i < 10; i++)
                cyc(1'b0, '0, 1'b0, 1'($urandom), 1'($urandom_range(0, 3) != 0), AW'($urandom),
                    1'b0, '0);
        end

        // Reset mid-RUN, then reads in IDLE are ignored.
        start(1'b0, 8'd0);
        for (int i = 0; i < 3; i++) sample(DW'($urandom));
        mid_reset();
        rd(4'd1);
        chk("idle_read_dvalid", 64'(o_data_valid), 64'(0));
        rd(4'd2);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
